// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects an asynchronous single-bit input.
// Produces a clean level, one-cycle rise/fall pulses and a wrapping rise count.
module input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_count
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_PEND_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_PEND_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_sync;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_W-1:0]       rise_count_q;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_q[gi] <= 1'b0;
                    else     sync_q[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_q[gi] <= 1'b0;
                    else     sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign d_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOW;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            rise_count_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_LOW, ST_PEND_HIGH: begin
                    if (d_sync && cnt_q == CNT_LAST) begin
                        level_q      <= 1'b1;
                        rise_q       <= 1'b1;
                        rise_count_q <= rise_count_q + CNT_W'(1);
                        cnt_q        <= '0;
                        state_q      <= ST_HIGH;
                    end else if (d_sync) begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_PEND_HIGH;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_LOW;
                    end
                end
                ST_HIGH, ST_PEND_LOW: begin
                    if (!d_sync && cnt_q == CNT_LAST) begin
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_LOW;
                    end else if (!d_sync) begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_PEND_LOW;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_HIGH;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_LOW;
                end
            endcase
        end
    end

    assign q          = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign rise_count = rise_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a run-length reference model.
module tb_input_conditioner;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CNT_W  = 8;

    logic             clk;
    logic             rst;
    logic             d;
    logic             q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] rise_count;

    int checks = 0;
    int errors = 0;

    // Reference model: delayed samples plus a run length of disagreeing samples.
    logic m_pipe [SYNC];
    logic m_q;
    logic m_rise;
    logic m_fall;
    int   m_run;
    int   m_count;

    input_conditioner #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .rise_count(rise_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic ds;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
            m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_count = 0;
        end else begin
            ds = m_pipe[SYNC-1];
            for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = d;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (ds != m_q) m_run++;
            else           m_run = 0;
            if (m_run == STABLE) begin
                m_run = 0;
                m_q   = ds;
                if (ds) begin
                    m_rise  = 1'b1;
                    m_count = (m_count + 1) % (1 << CNT_W);
                end else begin
                    m_fall = 1'b1;
                end
            end
        end
    endtask

    // One clock: model advances on the edge, outputs compared half a period later.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("q", {31'd0, q}, {31'd0, m_q});
        check("rise", {31'd0, rise}, {31'd0, m_rise});
        check("fall", {31'd0, fall}, {31'd0, m_fall});
        check("rise_count", {24'd0, rise_count}, m_count[31:0]);
        check("rise_and_fall", {31'd0, rise & fall}, 32'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts edges from now until q rises; expects the rise on edge exp_edge.
    task automatic expect_rise_at(input string tag, input int exp_edge);
        for (int i = 1; i <= exp_edge; i++) begin
            step();
            check({tag, "_q"}, {31'd0, q}, (i == exp_edge) ? 32'd1 : 32'd0);
            check({tag, "_rise"}, {31'd0, rise}, (i == exp_edge) ? 32'd1 : 32'd0);
        end
        step();
        check({tag, "_rise_end"}, {31'd0, rise}, 32'd0);
    endtask

    initial begin
        int run_len;
        int err0;
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_count = 0;
        rst = 1'b1;
        d   = 1'b0;

        // Reset with toggling input
        for (int i = 0; i < 3; i++) begin
            d = i[0];
            step();
            check("reset_q", {31'd0, q}, 32'd0);
            check("reset_count", {24'd0, rise_count}, 32'd0);
        end
        d = 1'b0;
        step();
        rst = 1'b0;
        steps(6);
        $display("reset: checks=%0d errors=%0d", checks, errors);

        // Clean rise: d changes before edge k, q rises on 6th sampling edge
        d = 1'b1;
        expect_rise_at("clean_rise", 6);
        check("clean_rise_count", {24'd0, rise_count}, 32'd1);
        steps(4);
        $display("clean rise: q=%0b rise_count=%0d", q, rise_count);

        // Clean fall
        d = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("clean_fall_q", {31'd0, q}, (i == 6) ? 32'd0 : 32'd1);
            check("clean_fall_pulse", {31'd0, fall}, (i == 6) ? 32'd1 : 32'd0);
        end
        step();
        check("clean_fall_end", {31'd0, fall}, 32'd0);
        check("clean_fall_count", {24'd0, rise_count}, 32'd1);
        steps(4);
        $display("clean fall: q=%0b rise_count=%0d", q, rise_count);

        // Bounce: 3 high, 1 low, then held high
        d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bounce_no_rise", {31'd0, rise}, 32'd0);
        end
        d = 1'b0;
        step();
        check("bounce_no_rise", {31'd0, rise}, 32'd0);
        d = 1'b1;
        expect_rise_at("bounce", 6);
        check("bounce_count", {24'd0, rise_count}, 32'd2);
        $display("bounce: q=%0b rise_count=%0d", q, rise_count);

        // Reset two edges into PEND_HIGH
        d = 1'b0;
        steps(10);
        d = 1'b1;
        steps(4);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("midreset_q", {31'd0, q}, 32'd0);
            check("midreset_rise", {31'd0, rise}, 32'd0);
        end
        rst = 1'b0;
        expect_rise_at("after_reset", 6);
        check("after_reset_count", {24'd0, rise_count}, 32'd1);
        $display("reset mid-debounce: q=%0b rise_count=%0d", q, rise_count);

        // Reset while HIGH: q drops without a fall pulse
        rst = 1'b1;
        step();
        check("reset_high_q", {31'd0, q}, 32'd0);
        check("reset_high_fall", {31'd0, fall}, 32'd0);
        d = 1'b0;
        step();
        rst = 1'b0;
        steps(6);

        // Counter wrap over 256 qualified rises
        err0 = errors;
        for (int n = 1; n <= 256; n++) begin
            d = 1'b1;
            steps(8);
            if (n == 255) check("wrap_ff", {24'd0, rise_count}, 32'h0000_00ff);
            if (n == 256) check("wrap_00", {24'd0, rise_count}, 32'd0);
            d = 1'b0;
            steps(8);
        end
        $display("wrap: rise_count=%0d new_errors=%0d", rise_count, errors - err0);

        // Random bouncing input with occasional resets
        err0 = errors;
        for (int t = 0; t < 300; t++) begin
            d = 1'($urandom_range(0, 1));
            run_len = $urandom_range(1, 8);
            if ($urandom_range(0, 30) == 0) begin
                rst = 1'b1;
                steps($urandom_range(1, 3));
                rst = 1'b0;
            end
            steps(run_len);
        end
        $display("random: checks=%0d new_errors=%0d", checks, errors - err0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
